// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - UART receive FIFO bus: rx capture side, FWFT consumer side and status.
// Optional stats signals exist only when UART_RX_FIFO_STATS_EN is defined.
interface uart_rx_fifo_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
);
  logic [DATA_W-1:0]   rx_out;
  logic                rx_over;
  logic [DATA_W-1:0]   dout;
  logic                dout_valid;
  logic                dout_ready;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;
  logic                overflow;
  logic                clr_ovf;
`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0]          drop_cnt;
  logic [DEPTH_LOG2:0] max_count;
`endif

  modport master (
    output rx_out, rx_over, dout_ready, clr_ovf,
`ifdef UART_RX_FIFO_STATS_EN
    input  drop_cnt, max_count,
`endif
    input  dout, dout_valid, count, full, empty, overflow
  );

  modport slave (
    input  rx_out, rx_over, dout_ready, clr_ovf,
`ifdef UART_RX_FIFO_STATS_EN
    output drop_cnt, max_count,
`endif
    output dout, dout_valid, count, full, empty, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - FWFT byte FIFO capturing UART bytes on rx_over rising edges.
// Define UART_RX_FIFO_STATS_EN to add drop_cnt and max_count statistics.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic              rx_over_q, arm_q, arm_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              push_req, pop, push_en, drop;

  // arm_q blocks a push until rx_over has been seen low after reset release
  always_comb begin
    push_req = bus.rx_over & ~rx_over_q & arm_q;
    pop      = ~empty_q & bus.dout_ready;
    push_en  = push_req & (~full_q | pop);
    drop     = push_req & full_q & ~pop;
    arm_d    = arm_q | ~bus.rx_over;

    wr_ptr_d = push_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = wr_ptr_d - rd_ptr_d;
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    ovf_d    = drop | (ovf_q & ~bus.clr_ovf);

    // The new head may be the byte being written this same edge, so bypass it
    dout_d = dout_q;
    if ((pop && !empty_d) || (push_en && empty_q)) begin
      if (push_en && (wr_ptr_q == rd_ptr_d)) dout_d = bus.rx_out;
      else                                   dout_d = mem[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q[AW-1:0]] <= bus.rx_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      rx_over_q <= 1'b0;
      arm_q     <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      rx_over_q <= bus.rx_over;
      arm_q     <= arm_d;
      dout_q    <= dout_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = ~empty_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.empty      = empty_q;
  assign bus.overflow   = ovf_q;

`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [AW:0] max_count_q, max_count_d;

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    max_count_d = max_count_q;
    if (bus.clr_ovf) begin
      drop_cnt_d  = drop ? 8'd1 : 8'd0;
      max_count_d = count_q;
    end else begin
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      if (count_d > max_count_q)       max_count_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q  <= '0;
      max_count_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      max_count_q <= max_count_d;
    end
  end

  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.max_count = max_count_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - Self-checking bench for uart_rx_fifo: vector table plus corner sequences.
module tb_uart_rx_fifo;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  uart_rx_fifo_if #(.DEPTH_LOG2(4), .DATA_W(8)) bus ();

  uart_rx_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rx_over;
    logic [7:0] rx_out;
    logic       ready;
    logic       clr;
    logic [4:0] cnt;
    logic       valid;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    bus.rx_out  = b;
    bus.rx_over = 1'b1;
    tick();
    bus.rx_over = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, {31'd0, bus.dout_valid}, 32'd1);
    chk(name, {24'd0, bus.dout}, {24'd0, exp});
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] b;
    int         sent;
    int         got;
    int         max_seen;
    logic       rdy;

    checks   = 0;
    failures = 0;
    rst_n          = 1'b0;
    bus.rx_out     = 8'h00;
    bus.rx_over    = 1'b0;
    bus.dout_ready = 1'b0;
    bus.clr_ovf    = 1'b0;

    // Reset held while rx_over toggles
    for (int i = 0; i < 4; i++) begin
      bus.rx_over = ~bus.rx_over;
      tick();
    end
    chk("rst_count", {27'd0, bus.count}, 32'd0);
    chk("rst_empty", {31'd0, bus.empty}, 32'd1);
    chk("rst_full", {31'd0, bus.full}, 32'd0);
    chk("rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_dout", {24'd0, bus.dout}, 32'd0);

    // rx_over high at release must not push until it falls and rises again
    bus.rx_over = 1'b1;
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("rst_held_no_push", {27'd0, bus.count}, 32'd0);
    bus.rx_over = 1'b0;
    tick();
    bus.rx_out  = 8'h5A;
    bus.rx_over = 1'b1;
    tick();
    chk("rearm_count", {27'd0, bus.count}, 32'd1);
    bus.rx_over = 1'b0;
    pop_check("rearm_dout", 8'h5A);
    chk("rearm_empty", {31'd0, bus.empty}, 32'd1);

    // Vector table: one clock per row, outputs checked just after the edge
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'h11, 1'b1, 1'b0, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h22, 1'b1, 1'b0, 5'd1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 5'd2, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bus.rx_over    = vecs[i].rx_over;
      bus.rx_out     = vecs[i].rx_out;
      bus.dout_ready = vecs[i].ready;
      bus.clr_ovf    = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_count", i), {27'd0, bus.count}, {27'd0, vecs[i].cnt});
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.dout_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("vec%0d_dout", i), {24'd0, bus.dout}, {24'd0, vecs[i].dout});
      chk($sformatf("vec%0d_full", i), {31'd0, bus.full}, {31'd0, vecs[i].full});
      chk($sformatf("vec%0d_empty", i), {31'd0, bus.empty}, {31'd0, vecs[i].empty});
      chk($sformatf("vec%0d_ovf", i), {31'd0, bus.overflow}, {31'd0, vecs[i].ovf});
    end
    bus.rx_over = 1'b0; bus.dout_ready = 1'b0; bus.clr_ovf = 1'b0;
    tick();

    // Fill to full, drop one byte, drain in order
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    chk("fill_full", {31'd0, bus.full}, 32'd1);
    chk("fill_count", {27'd0, bus.count}, 32'd16);
    chk("fill_ovf", {31'd0, bus.overflow}, 32'd0);
    push_byte(8'hFF);
    chk("drop_ovf", {31'd0, bus.overflow}, 32'd1);
    chk("drop_count", {27'd0, bus.count}, 32'd16);
`ifdef UART_RX_FIFO_STATS_EN
    chk("drop_cnt", {24'd0, bus.drop_cnt}, 32'd1);
    chk("max_count", {27'd0, bus.max_count}, 32'd16);
`endif
    for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i), 8'(i));
    chk("drain_empty", {31'd0, bus.empty}, 32'd1);
    chk("drain_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("clr_ovf", {31'd0, bus.overflow}, 32'd0);
`ifdef UART_RX_FIFO_STATS_EN
    chk("clr_drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
`endif

    // Full with simultaneous push and pop: no drop, count stays at 16
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
    bus.rx_out     = 8'h55;
    bus.rx_over    = 1'b1;
    bus.dout_ready = 1'b1;
    tick();
    bus.rx_over    = 1'b0;
    bus.dout_ready = 1'b0;
    chk("fullpp_count", {27'd0, bus.count}, 32'd16);
    chk("fullpp_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("fullpp_full", {31'd0, bus.full}, 32'd1);
    for (int i = 1; i < 16; i++) pop_check($sformatf("fullpp%0d", i), 8'h80 + 8'(i));
    pop_check("fullpp_last", 8'h55);
    chk("fullpp_empty", {31'd0, bus.empty}, 32'd1);

    // Asynchronous reset mid-operation discards contents at once
    push_byte(8'h01);
    push_byte(8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", {27'd0, bus.count}, 32'd0);
    chk("async_rst_valid", {31'd0, bus.dout_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Streaming with random stalls, pointers wrap twice
    sent = 0; got = 0; max_seen = 0;
    for (int cyc = 0; cyc < 600 && (sent < 40 || q.size() != 0); cyc++) begin
      if (int'(bus.count) > max_seen) max_seen = int'(bus.count);
      rdy = (sent >= 40) || ($urandom_range(0, 3) != 0) || (bus.count >= 5'd12);
      if (bus.dout_valid && rdy) begin
        if (q.size() == 0) chk("stream_unexpected", {24'd0, bus.dout}, 32'hFFFF_FFFF);
        else begin
          b = q.pop_front();
          chk($sformatf("stream%0d", got), {24'd0, bus.dout}, {24'd0, b});
          got++;
        end
      end
      if ((cyc % 2) == 0 && sent < 40) begin
        b = 8'(sent * 7 + 3);
        bus.rx_out  = b;
        bus.rx_over = 1'b1;
        q.push_back(b);
        sent++;
      end else begin
        bus.rx_over = 1'b0;
      end
      bus.dout_ready = rdy;
      tick();
    end
    bus.rx_over = 1'b0; bus.dout_ready = 1'b0;
    chk("stream_got", got, 32'd40);
    chk("stream_max_le16", {31'd0, max_seen <= 16}, 32'd1);
    chk("stream_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("stream_empty", {31'd0, bus.empty}, 32'd1);

    // rx_over held high for 10 clocks pushes a single byte
    bus.rx_out  = 8'h77;
    bus.rx_over = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.rx_over = 1'b0;
    tick();
    chk("hold_one_push", {27'd0, bus.count}, 32'd1);

    // clr_ovf together with a drop: the set wins
    for (int i = 1; i < 16; i++) push_byte(8'hC0 + 8'(i));
    chk("hold_full", {31'd0, bus.full}, 32'd1);
    push_byte(8'hDD);
    chk("hold_drop_ovf", {31'd0, bus.overflow}, 32'd1);
    bus.rx_out  = 8'hEE;
    bus.rx_over = 1'b1;
    bus.clr_ovf = 1'b1;
    tick();
    bus.rx_over = 1'b0;
    bus.clr_ovf = 1'b0;
    chk("clr_with_drop_ovf", {31'd0, bus.overflow}, 32'd1);
    chk("clr_with_drop_count", {27'd0, bus.count}, 32'd16);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("clr_alone_ovf", {31'd0, bus.overflow}, 32'd0);
    pop_check("hold_head", 8'h77);
    for (int i = 1; i < 16; i++) pop_check($sformatf("hold%0d", i), 8'hC0 + 8'(i));
    chk("hold_empty", {31'd0, bus.empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
